// File: rtl/ifetch_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifetch_prefetch_pkg;

    localparam int          FETCH_DEPTH = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/ifetch_prefetch_fifo.sv
// Generic in-order FIFO with synchronous flush; head is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags, head view and handshake qualification.
    always_comb begin
        empty     = (count_r == {(AW+1){1'b0}});
        count     = count_r;
        head_data = mem_r[rd_ptr_r];
        do_pop_s  = pop & ~empty;
        do_push_s = push & ((count_r != (AW+1)'(DEPTH)) | do_pop_s);
    end

    // Entry storage; flush suppresses any write in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
        end
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: credit-limited memory reads, in-order response buffering,
// and redirect handling that flushes the queue and drops stale in-flight responses.
module ifetch_prefetch
    import ifetch_prefetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          started_r;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;

    logic [CW-1:0] outstanding_next_s;
    logic [CW-1:0] discard_next_s;
    logic [CW-1:0] fifo_count_s;
    logic [CW:0]   in_use_s;
    logic          credit_s;
    logic          grant_s;
    logic          drop_s;
    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_entry_s;

    // Request side: only issue when a queue slot is guaranteed for the response.
    always_comb begin
        in_use_s = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        credit_s = (in_use_s < (CW+1)'(DEPTH));
        mem_req  = started_r & credit_s & ~redirect_valid;
        if (started_r) begin
            mem_addr = fetch_pc_r;
        end else begin
            mem_addr = 32'h0;
        end
        grant_s = mem_req & mem_gnt;
    end

    // Response side: drop while stale responses remain, or when a redirect lands now.
    always_comb begin
        drop_s             = mem_rvalid & (redirect_valid | (discard_r != {CW{1'b0}}));
        push_s             = mem_rvalid & ~drop_s;
        push_entry_s.pc    = resp_pc_r;
        push_entry_s.instr = mem_rdata;
        pop_s              = ~fifo_empty_s & out_ready & ~redirect_valid;
        outstanding_next_s = outstanding_r + CW'(grant_s) - CW'(mem_rvalid);
        if (redirect_valid) begin
            discard_next_s = outstanding_next_s;
        end else if (mem_rvalid && (discard_r != {CW{1'b0}})) begin
            discard_next_s = discard_r - CW'(1'b1);
        end else begin
            discard_next_s = discard_r;
        end
    end

    // Fetch/response PCs and in-flight bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            started_r     <= 1'b0;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
        end else begin
            started_r     <= 1'b1;
            outstanding_r <= outstanding_next_s;
            discard_r     <= discard_next_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_pc;
                resp_pc_r  <= redirect_pc;
            end else begin
                if (grant_s) begin
                    fetch_pc_r <= pc_incr(fetch_pc_r);
                end
                if (push_s) begin
                    resp_pc_r <= pc_incr(resp_pc_r);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head_data (head_entry_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Core-facing view of the queue head; zeros when nothing is buffered.
    always_comb begin
        out_valid = ~fifo_empty_s;
        if (out_valid) begin
            out_pc    = head_entry_s.pc;
            out_instr = head_entry_s.instr;
        end else begin
            out_pc    = 32'h0;
            out_instr = 32'h0;
        end
    end

endmodule
